// File: rtl/ssm2603_pkg.sv
// ssm2603_pkg
// Definitions shared by the SSM2603 ADC capture and DAC serializer blocks:
//   - capture_state_t : capture FSM encoding (IDLE, DELAY, SHIFT, PAD)
//   - SAMPLE_BITS_DEFAULT : default per-channel sample width
//   - BCLK_PER_FRAME / CLK_PER_BCLK : I2S frame geometry at 18.432 MHz
package ssm2603_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // waiting for the first word-select edge
    DELAY = 2'd1,  // swallowing the I2S one-bit delay
    SHIFT = 2'd2,  // capturing sample bits MSB first
    PAD   = 2'd3   // ignoring bits beyond the sample width
  } capture_state_t;

  localparam int SAMPLE_BITS_DEFAULT = 16;
  localparam int BCLK_PER_FRAME      = 64;
  localparam int CLK_PER_BCLK        = 9;

endpackage

// File: rtl/ssm2603_adc_capture_sync_edge.sv
// sync_edge
// Multi-flop synchronizer for a slow external level, followed by a history
// flop used for edge detection.
// Ports:
//   clock  : system clock
//   reset  : synchronous, active-low
//   d      : asynchronous input pin
//   level  : synchronized level
//   rise   : one-cycle strobe on a synchronized 0->1 transition
//   change : one-cycle strobe on any synchronized transition
module sync_edge
  import ssm2603_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic change
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   hist_q;
  logic                   hist_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    hist_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign level  = sync_q[SYNC_STAGES-1];
  assign rise   = level & ~hist_q;
  assign change = level ^ hist_q;

endmodule

// File: rtl/ssm2603_adc_capture.sv
// ssm2603_adc_capture
// Deserializes the SSM2603 ADC I2S stream into signed left/right sample
// pairs presented on a valid/ready port. BCLK and LRCLK are oversampled on
// the system clock; no other clock domain exists.
// Optional feature macro: ADC_CAPTURE_PEAK_EN adds peak_l/peak_r, the running
// maximum |sample| (saturating) of pairs loaded onto the port.
// Ports:
//   clock, reset         : system clock, synchronous active-low reset
//   adc_bclk/lrclk/dat   : codec I2S pins (treated as data)
//   sample_l/sample_r    : presented pair
//   sample_valid/ready   : handshake
//   overrun              : sticky, a completed pair was dropped
//   frame_error          : sticky, a slot ended before a full word
//   status_clear         : clears sticky flags and peaks
//   peak_l/peak_r        : (ADC_CAPTURE_PEAK_EN only) peak magnitudes
module ssm2603_adc_capture
  import ssm2603_pkg::*;
#(
  parameter int SAMPLE_BITS = SAMPLE_BITS_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   adc_bclk,
  input  logic                   adc_lrclk,
  input  logic                   adc_dat,
  output logic [SAMPLE_BITS-1:0] sample_l,
  output logic [SAMPLE_BITS-1:0] sample_r,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  output logic                   overrun,
  output logic                   frame_error,
  input  logic                   status_clear
`ifdef ADC_CAPTURE_PEAK_EN
  ,
  output logic [SAMPLE_BITS-1:0] peak_l,
  output logic [SAMPLE_BITS-1:0] peak_r
`endif
);

  localparam int CNT_W = $clog2(SAMPLE_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SAMPLE_BITS - 1);

  // ---------------------------------------------------------------- inputs
  logic bclk_level, bclk_rise, bclk_change;
  logic lr_level, lr_rise, lr_edge;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_bclk_sync (
    .clock  (clock),
    .reset  (reset),
    .d      (adc_bclk),
    .level  (bclk_level),
    .rise   (bclk_rise),
    .change (bclk_change)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_lrclk_sync (
    .clock  (clock),
    .reset  (reset),
    .d      (adc_lrclk),
    .level  (lr_level),
    .rise   (lr_rise),
    .change (lr_edge)
  );

  logic unused_sync;
  assign unused_sync = &{1'b0, bclk_level, bclk_change, lr_rise};

  // Data gets the same depth as the clocks so it stays aligned with
  // the synchronized bclk edge.
  logic [SYNC_STAGES-1:0] dat_sync_q;
  logic [SYNC_STAGES-1:0] dat_sync_d;
  logic                   dat_bit;

  always_comb begin
    dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], adc_dat};
  end

  assign dat_bit = dat_sync_q[SYNC_STAGES-1];

  // ------------------------------------------------------------------ state
  capture_state_t state_q, state_d;

  logic                   channel_q, channel_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_BITS-2:0] shift_q, shift_d;
  logic [SAMPLE_BITS-1:0] hold_l_q, hold_l_d;
  logic [SAMPLE_BITS-1:0] hold_r_q, hold_r_d;
  logic                   left_seen_q, left_seen_d;
  logic                   pair_q, pair_d;
  logic [SAMPLE_BITS-1:0] sample_l_q, sample_l_d;
  logic [SAMPLE_BITS-1:0] sample_r_q, sample_r_d;
  logic                   sample_valid_q, sample_valid_d;
  logic                   overrun_q, overrun_d;
  logic                   frame_error_q, frame_error_d;

  logic                   frame_err_evt;
  logic                   overrun_evt;
  logic                   load_pair;
  logic [SAMPLE_BITS-1:0] word;

  // Final bit goes straight into the stored word; the shift register only
  // needs to hold the SAMPLE_BITS-1 bits before it.
  assign word = {shift_q, dat_bit};

  // -------------------------------------------------------- state register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ------------------------------------------------------------ next state
  always_comb begin
    state_d = state_q;
    if (lr_edge) begin
      state_d = DELAY;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        DELAY:   if (bclk_rise) state_d = SHIFT;
        SHIFT:   if (bclk_rise && (bit_cnt_q == LAST_BIT)) state_d = PAD;
        PAD:     state_d = PAD;
        default: state_d = IDLE;
      endcase
    end
  end

  // ------------------------------------------------------- outputs / data
  always_comb begin
    channel_d     = channel_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    hold_l_d      = hold_l_q;
    hold_r_d      = hold_r_q;
    left_seen_d   = left_seen_q;
    pair_d        = 1'b0;
    frame_err_evt = 1'b0;

    if (lr_edge) begin
      channel_d = lr_level;
      bit_cnt_d = '0;
      // SHIFT always means fewer than SAMPLE_BITS bits are in hand.
      if (state_q == SHIFT) frame_err_evt = 1'b1;
    end else if ((state_q == SHIFT) && bclk_rise) begin
      shift_d   = word[SAMPLE_BITS-2:0];
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
      if (bit_cnt_q == LAST_BIT) begin
        if (!channel_q) begin
          hold_l_d    = word;
          left_seen_d = 1'b1;
        end else if (left_seen_q) begin
          hold_r_d    = word;
          left_seen_d = 1'b0;
          pair_d      = 1'b1;
        end
      end
    end

    // Output port: a completed pair loads when the slot is free or being
    // vacated this cycle; otherwise it is dropped and flagged.
    load_pair      = pair_q && (!sample_valid_q || sample_ready);
    overrun_evt    = pair_q && sample_valid_q && !sample_ready;
    sample_l_d     = sample_l_q;
    sample_r_d     = sample_r_q;
    sample_valid_d = sample_valid_q;
    if (load_pair) begin
      sample_l_d     = hold_l_q;
      sample_r_d     = hold_r_q;
      sample_valid_d = 1'b1;
    end else if (sample_ready) begin
      sample_valid_d = 1'b0;
    end

    // A new event outranks a coincident clear.
    overrun_d     = (overrun_q & ~status_clear) | overrun_evt;
    frame_error_d = (frame_error_q & ~status_clear) | frame_err_evt;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      dat_sync_q     <= '0;
      channel_q      <= 1'b0;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      hold_l_q       <= '0;
      hold_r_q       <= '0;
      left_seen_q    <= 1'b0;
      pair_q         <= 1'b0;
      sample_l_q     <= '0;
      sample_r_q     <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
      frame_error_q  <= 1'b0;
    end else begin
      dat_sync_q     <= dat_sync_d;
      channel_q      <= channel_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      hold_l_q       <= hold_l_d;
      hold_r_q       <= hold_r_d;
      left_seen_q    <= left_seen_d;
      pair_q         <= pair_d;
      sample_l_q     <= sample_l_d;
      sample_r_q     <= sample_r_d;
      sample_valid_q <= sample_valid_d;
      overrun_q      <= overrun_d;
      frame_error_q  <= frame_error_d;
    end
  end

  assign sample_l     = sample_l_q;
  assign sample_r     = sample_r_q;
  assign sample_valid = sample_valid_q;
  assign overrun      = overrun_q;
  assign frame_error  = frame_error_q;

`ifdef ADC_CAPTURE_PEAK_EN
  // ------------------------------------------------------------ peak meter
  localparam logic [SAMPLE_BITS-1:0] MAX_POS = {1'b0, {(SAMPLE_BITS-1){1'b1}}};
  localparam logic [SAMPLE_BITS-1:0] MIN_NEG = {1'b1, {(SAMPLE_BITS-1){1'b0}}};

  // Magnitude of a two's-complement sample; the most negative value has no
  // positive counterpart and saturates to MAX_POS.
  function automatic logic [SAMPLE_BITS-1:0] abs_sat(input logic [SAMPLE_BITS-1:0] x);
    if (!x[SAMPLE_BITS-1]) return x;
    else if (x == MIN_NEG) return MAX_POS;
    else return -x;
  endfunction

  logic [SAMPLE_BITS-1:0] peak_l_q, peak_l_d;
  logic [SAMPLE_BITS-1:0] peak_r_q, peak_r_d;
  logic [SAMPLE_BITS-1:0] abs_l, abs_r;

  always_comb begin
    abs_l    = abs_sat(hold_l_q);
    abs_r    = abs_sat(hold_r_q);
    peak_l_d = peak_l_q;
    peak_r_d = peak_r_q;
    if (status_clear) begin
      peak_l_d = load_pair ? abs_l : '0;
      peak_r_d = load_pair ? abs_r : '0;
    end else if (load_pair) begin
      if (abs_l > peak_l_q) peak_l_d = abs_l;
      if (abs_r > peak_r_q) peak_r_d = abs_r;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      peak_l_q <= '0;
      peak_r_q <= '0;
    end else begin
      peak_l_q <= peak_l_d;
      peak_r_q <= peak_r_d;
    end
  end

  assign peak_l = peak_l_q;
  assign peak_r = peak_r_q;
`endif

endmodule

// File: tb/tb_ssm2603_adc_capture.sv
// Testbench for ssm2603_adc_capture: drives an I2S ADC stream (BCLK of
// 9 system clocks, 32 BCLKs per slot) and checks presented pairs against a
// queue of expected pairs, plus directed checks of flags and reset.
module tb_ssm2603_adc_capture;

  localparam int SB = 16;

  typedef struct packed {
    logic [SB-1:0] l;
    logic [SB-1:0] r;
  } pair_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          adc_bclk, adc_lrclk, adc_dat;
  logic [SB-1:0] sample_l, sample_r;
  logic          sample_valid, sample_ready;
  logic          overrun, frame_error, status_clear;
`ifdef ADC_CAPTURE_PEAK_EN
  logic [SB-1:0] peak_l, peak_r;
`endif

  int    errors = 0;
  int    checks = 0;
  pair_t exp_q[$];
  pair_t vec[5];

  always #5 clock = ~clock;

  ssm2603_adc_capture #(.SAMPLE_BITS(SB), .SYNC_STAGES(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .adc_bclk     (adc_bclk),
    .adc_lrclk    (adc_lrclk),
    .adc_dat      (adc_dat),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .frame_error  (frame_error),
    .status_clear (status_clear)
`ifdef ADC_CAPTURE_PEAK_EN
    ,
    .peak_l       (peak_l),
    .peak_r       (peak_r)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  // Inputs change 3 time units after the rising edge.
  task automatic tick();
    @(posedge clock);
    #3;
  endtask

  // One BCLK period: falling edge with new data, 5 clocks low, 4 high.
  task automatic bclk_bit(input logic d);
    adc_bclk = 1'b0;
    adc_dat  = d;
    repeat (5) tick();
    adc_bclk = 1'b1;
    repeat (4) tick();
  endtask

  // A slot of nb BCLKs; the MSB follows one BCLK after the LRCLK change.
  task automatic slot(input logic lr, input logic [SB-1:0] w, input int nb);
    for (int k = 0; k < nb; k++) begin
      if (k == 0) adc_lrclk = lr;
      bclk_bit((k >= 1 && k <= SB) ? w[SB-k] : 1'b0);
    end
  endtask

  task automatic frame(input logic [SB-1:0] l, input logic [SB-1:0] r);
    slot(1'b0, l, 32);
    slot(1'b1, r, 32);
  endtask

  task automatic push(input logic [SB-1:0] l, input logic [SB-1:0] r);
    pair_t p;
    p.l = l;
    p.r = r;
    exp_q.push_back(p);
  endtask

  task automatic pulse_clear();
    status_clear = 1'b1;
    tick();
    status_clear = 1'b0;
    tick();
  endtask

  // Scoreboard: every accepted handshake must match the oldest expectation.
  always @(negedge clock) begin
    if (reset && sample_valid && sample_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pair actual l=%h r=%h required none", sample_l, sample_r);
      end else begin
        pair_t e;
        e = exp_q.pop_front();
        chk("pair_l", 32'(sample_l), 32'(e.l));
        chk("pair_r", 32'(sample_r), 32'(e.r));
      end
    end
  end

  initial begin
    vec[0] = '{l: 16'h8001, r: 16'h7FFE};
    vec[1] = '{l: 16'h0000, r: 16'hFFFF};
    vec[2] = '{l: 16'h1234, r: 16'h5678};
    vec[3] = '{l: 16'hA5A5, r: 16'h5A5A};
    vec[4] = '{l: 16'h7FFF, r: 16'h8000};

    reset        = 1'b0;
    adc_bclk     = 1'b0;
    adc_lrclk    = 1'b1;
    adc_dat      = 1'b0;
    sample_ready = 1'b1;
    status_clear = 1'b0;
    repeat (4) tick();

    chk("rst_valid", 32'(sample_valid), 0);
    chk("rst_l", 32'(sample_l), 0);
    chk("rst_r", 32'(sample_r), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_frame_error", 32'(frame_error), 0);
    reset = 1'b1;

    // Capture begins mid-right-slot: that word has no left partner.
    slot(1'b1, 16'hBEEF, 20);
    chk("midright_valid", 32'(sample_valid), 0);
    chk("midright_frame_error", 32'(frame_error), 0);

    for (int i = 0; i < 5; i++) begin
      push(vec[i].l, vec[i].r);
      frame(vec[i].l, vec[i].r);
    end
    chk("table_overrun", 32'(overrun), 0);
    chk("table_frame_error", 32'(frame_error), 0);

    // Back-pressure across two frames.
    sample_ready = 1'b0;
    frame(16'hC0DE, 16'h0BAD);
    chk("bp_valid", 32'(sample_valid), 1);
    chk("bp_l", 32'(sample_l), 32'h0000C0DE);
    chk("bp_r", 32'(sample_r), 32'h00000BAD);
    chk("bp_overrun_before", 32'(overrun), 0);
    frame(16'h1234, 16'h5678);
    chk("bp_overrun_after", 32'(overrun), 1);
    chk("bp_hold_l", 32'(sample_l), 32'h0000C0DE);
    chk("bp_hold_r", 32'(sample_r), 32'h00000BAD);
    push(16'hC0DE, 16'h0BAD);
    sample_ready = 1'b1;
    repeat (3) tick();
    chk("bp_drained", 32'(sample_valid), 0);
    pulse_clear();
    chk("bp_overrun_cleared", 32'(overrun), 0);

    // Short left slot: LRCLK toggles after 10 data bits.
    slot(1'b0, 16'hFFFF, 11);
    slot(1'b1, 16'h1111, 32);
    chk("ferr_set", 32'(frame_error), 1);
    chk("ferr_no_pair", 32'(sample_valid), 0);
    push(16'h2468, 16'h9BDF);
    frame(16'h2468, 16'h9BDF);
    chk("ferr_sticky", 32'(frame_error), 1);
    pulse_clear();
    chk("ferr_cleared", 32'(frame_error), 0);

    // Reset for one clock in the middle of a right word.
    sample_ready = 1'b0;
    frame(16'h0F0F, 16'hF0F0);
    chk("prerst_valid", 32'(sample_valid), 1);
    slot(1'b0, 16'h3333, 32);
    slot(1'b1, 16'h4444, 10);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("midrst_valid", 32'(sample_valid), 0);
    chk("midrst_l", 32'(sample_l), 0);
    chk("midrst_r", 32'(sample_r), 0);
    chk("midrst_overrun", 32'(overrun), 0);
    sample_ready = 1'b1;
    slot(1'b1, 16'h4444, 20);
    push(16'h5A5A, 16'hC3C3);
    frame(16'h5A5A, 16'hC3C3);
    chk("postrst_frame_error", 32'(frame_error), 0);
    chk("postrst_overrun", 32'(overrun), 0);

`ifdef ADC_CAPTURE_PEAK_EN
    pulse_clear();
    push(16'hFED4, 16'h00C8);
    frame(16'hFED4, 16'h00C8);
    chk("peak_l_300", 32'(peak_l), 32'd300);
    chk("peak_r_200", 32'(peak_r), 32'd200);
    push(16'h8000, 16'h0000);
    frame(16'h8000, 16'h0000);
    chk("peak_l_sat", 32'(peak_l), 32'd32767);
    chk("peak_r_keep", 32'(peak_r), 32'd200);
    pulse_clear();
    chk("peak_l_clr", 32'(peak_l), 0);
    chk("peak_r_clr", 32'(peak_r), 0);
`endif

    repeat (20) tick();
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
